// File: rtl/parity_pkg.sv
// Shared types and constants for the parity frame receiver and its checker stage.
package parity_pkg;

   localparam int PARITY_DATA_W_MAX = 8;
   localparam int PARITY_CNT_W      = $clog2(PARITY_DATA_W_MAX);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PAR,
      STOP
   } rx_state_t;

endpackage

// File: rtl/parity_out_reg.sv
// Output holding register: presents one word with status flags on valid/ready and
// flags a sticky overrun when a new word arrives while the held one is unaccepted.
module parity_out_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         par_err_i,
   input  logic         frm_err_i,
   input  logic         ready_i,
   input  logic         ovr_clr,
   output logic [W-1:0] data_o,
   output logic         par_err_o,
   output logic         frm_err_o,
   output logic         valid_o,
   output logic         overrun_o
);

   logic [W-1:0] data_q, data_d;
   logic         par_err_q, par_err_d;
   logic         frm_err_q, frm_err_d;
   logic         valid_q, valid_d;
   logic         overrun_q, overrun_d;
   logic         ovr_set;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      data_d    = data_q;
      par_err_d = par_err_q;
      frm_err_d = frm_err_q;
      valid_d   = valid_q;
      ovr_set   = 1'b0;
      if (load_i) begin
         // A word may replace the held one only when the slot is empty or being drained now.
         if (!valid_q || ready_i) begin
            data_d    = data_i;
            par_err_d = par_err_i;
            frm_err_d = frm_err_i;
            valid_d   = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      overrun_d = ovr_clr ? 1'b0 : (overrun_q | ovr_set);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q    <= '0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         par_err_q <= par_err_d;
         frm_err_q <= frm_err_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign data_o    = data_q;
   assign par_err_o = par_err_q;
   assign frm_err_o = frm_err_q;
   assign valid_o   = valid_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Strobed serial frame receiver (start, DATA_W bits LSB first, parity, stop).
// Define PARITY_FRAME_RX_ODD_PARITY_EN for odd parity; even parity otherwise.
module parity_frame_rx
   import parity_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_stb,
   input  logic              sd,
   output logic [DATA_W-1:0] data_o,
   output logic              par_err_o,
   output logic              frm_err_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              overrun_o,
   input  logic              ovr_clr
);

   localparam logic [PARITY_CNT_W-1:0] CNT_LAST = PARITY_CNT_W'(DATA_W - 1);

   rx_state_t                state_q, state_d;
   logic [PARITY_CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0]        shift_q, shift_d;
   logic                     p_q, p_d;
   logic                     frame_done;
   logic                     par_err;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      p_d        = p_q;
      frame_done = 1'b0;
      if (bit_stb) begin
         case (state_q)
            IDLE: begin
               if (!sd) begin
                  state_d = DATA;
                  cnt_d   = '0;
                  p_d     = 1'b0;
               end
            end
            DATA: begin
               // Right shift: after DATA_W samples the first (LSB) bit sits at index 0.
               shift_d = {sd, shift_q[DATA_W-1:1]};
               p_d     = p_q ^ sd;
               if (cnt_q == CNT_LAST) begin
                  state_d = PAR;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            PAR: begin
               p_d     = p_q ^ sd;
               state_d = STOP;
            end
            STOP: begin
               frame_done = 1'b1;
               state_d    = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef PARITY_FRAME_RX_ODD_PARITY_EN
   assign par_err = ~p_q;
`else
   assign par_err = p_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         p_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         p_q     <= p_d;
      end
   end

   parity_out_reg #(
      .W (DATA_W)
   ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (frame_done),
      .data_i    (shift_q),
      .par_err_i (par_err),
      .frm_err_i (~sd),
      .ready_i   (ready_i),
      .ovr_clr   (ovr_clr),
      .data_o    (data_o),
      .par_err_o (par_err_o),
      .frm_err_o (frm_err_o),
      .valid_o   (valid_o),
      .overrun_o (overrun_o)
   );

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed and randomised frames against a bit-list reference model of the receiver.
module tb_parity_frame_rx;

   localparam int DATA_W = 8;

   logic              clk;
   logic              rst_n;
   logic              bit_stb;
   logic              sd;
   logic [DATA_W-1:0] data_o;
   logic              par_err_o;
   logic              frm_err_o;
   logic              valid_o;
   logic              ready_i;
   logic              overrun_o;
   logic              ovr_clr;

   int total;
   int bad;

   // Reference model: collected frame bits plus the expected output register.
   logic              in_frame;
   int                nbits;
   logic [DATA_W+1:0] bits;
   logic [DATA_W-1:0] m_data;
   logic              m_par;
   logic              m_frm;
   logic              m_valid;
   logic              m_ovr;

   parity_frame_rx #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_stb   (bit_stb),
      .sd        (sd),
      .data_o    (data_o),
      .par_err_o (par_err_o),
      .frm_err_o (frm_err_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .overrun_o (overrun_o),
      .ovr_clr   (ovr_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      in_frame = 1'b0;
      nbits    = 0;
      bits     = '0;
      m_data   = '0;
      m_par    = 1'b0;
      m_frm    = 1'b0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
   endtask

   task automatic model_step(input logic stb, input logic sdv, input logic rdy, input logic clr);
      logic done;
      logic ovr_evt;
      int   ones;
      done    = 1'b0;
      ovr_evt = 1'b0;
      if (stb) begin
         if (!in_frame) begin
            if (!sdv) begin
               in_frame = 1'b1;
               nbits    = 0;
            end
         end else begin
            bits[nbits] = sdv;
            nbits++;
            if (nbits == DATA_W + 2) begin
               done     = 1'b1;
               in_frame = 1'b0;
            end
         end
      end
      if (done) begin
         if (!m_valid || rdy) begin
            ones   = $countones(bits[DATA_W:0]);
            m_data = bits[DATA_W-1:0];
`ifdef PARITY_FRAME_RX_ODD_PARITY_EN
            m_par  = (ones % 2) == 0;
`else
            m_par  = (ones % 2) != 0;
`endif
            m_frm   = ~bits[DATA_W+1];
            m_valid = 1'b1;
         end else begin
            ovr_evt = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      if (clr)          m_ovr = 1'b0;
      else if (ovr_evt) m_ovr = 1'b1;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_valid"},   32'(valid_o),   32'(m_valid));
      check({tag, "_data"},    32'(data_o),    32'(m_data));
      check({tag, "_par_err"}, 32'(par_err_o), 32'(m_par));
      check({tag, "_frm_err"}, 32'(frm_err_o), 32'(m_frm));
      check({tag, "_overrun"}, 32'(overrun_o), 32'(m_ovr));
   endtask

   task automatic tick(input logic stb, input logic sdv, input logic rdy, input logic clr);
      @(negedge clk);
      bit_stb = stb;
      sd      = sdv;
      ready_i = rdy;
      ovr_clr = clr;
      @(posedge clk);
      model_step(stb, sdv, rdy, clr);
      #1;
      check_outputs("cyc");
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] data, input logic pb, input logic sb,
                             input int gap, input logic rdy_body, input logic rdy_stop);
      logic [DATA_W+2:0] fr;
      fr = {sb, pb, data, 1'b0};
      for (int i = 0; i <= DATA_W + 2; i++) begin
         repeat (gap - 1) tick(1'b0, fr[i], rdy_body, 1'b0);
         tick(1'b1, fr[i], (i == DATA_W + 2) ? rdy_stop : rdy_body, 1'b0);
      end
   endtask

   initial begin
      logic [DATA_W-1:0] rd;
      logic [DATA_W+2:0] part;
      total   = 0;
      bad     = 0;
      rst_n   = 1'b0;
      bit_stb = 1'b0;
      sd      = 1'b1;
      ready_i = 1'b0;
      ovr_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Clean 0x0F frame, one strobe per cycle.
      send_frame(8'h0F, 1'b0, 1'b1, 1, 1'b0, 1'b0);
      check("t1_data", 32'(data_o), 32'h0F);
      check("t1_valid", 32'(valid_o), 32'd1);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      check("t1_accepted", 32'(valid_o), 32'd0);

      // 0xA5 with parity bit 1: five ones in total.
      send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b0, 1'b0);
`ifdef PARITY_FRAME_RX_ODD_PARITY_EN
      check("t2_par_err", 32'(par_err_o), 32'd0);
`else
      check("t2_par_err", 32'(par_err_o), 32'd1);
`endif
      tick(1'b0, 1'b1, 1'b1, 1'b0);

      // Framing error, then a back-to-back frame whose start bit follows the bad stop bit.
      send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0);
      check("t3_frm_err", 32'(frm_err_o), 32'd1);
      check("t3_data", 32'(data_o), 32'h3C);
      send_frame(8'h01, 1'b1, 1'b1, 1, 1'b1, 1'b1);
      check("t3_next_data", 32'(data_o), 32'h01);
      check("t3_next_frm", 32'(frm_err_o), 32'd0);
      tick(1'b0, 1'b1, 1'b1, 1'b0);

      // Overrun: two frames with ready held low.
      send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1, 1'b0, 1'b0);
      check("t4_data_kept", 32'(data_o), 32'h11);
      check("t4_overrun", 32'(overrun_o), 32'd1);
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      check("t4_valid_clr", 32'(valid_o), 32'd0);
      check("t4_ovr_clr", 32'(overrun_o), 32'd0);

      // Sparse strobes, reset after the 4th data bit.
      part = {1'b1, 1'b0, 8'h5A, 1'b0};
      for (int i = 0; i <= 4; i++) begin
         repeat (6) tick(1'b0, part[i], 1'b0, 1'b0);
         tick(1'b1, part[i], 1'b0, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #2;
      check_outputs("t5_reset");
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(8'h80, 1'b1, 1'b1, 7, 1'b0, 1'b0);
      check("t5_data", 32'(data_o), 32'h80);
      check("t5_par_ok", 32'(par_err_o), 32'd0);
      tick(1'b0, 1'b1, 1'b1, 1'b0);

      // Accept coincides with the stop sample of the next frame.
      send_frame(8'h55, 1'b0, 1'b1, 1, 1'b0, 1'b0);
      send_frame(8'hAA, 1'b0, 1'b1, 1, 1'b0, 1'b1);
      check("t6_data", 32'(data_o), 32'hAA);
      check("t6_valid", 32'(valid_o), 32'd1);
      check("t6_no_ovr", 32'(overrun_o), 32'd0);
      tick(1'b0, 1'b1, 1'b1, 1'b0);

      // Randomised frames, gaps, handshakes and overrun clears.
      for (int n = 0; n < 40; n++) begin
         rd = DATA_W'($urandom);
         send_frame(rd, 1'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(1, 3),
                    1'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 3))
            tick(1'b0, 1'b1, 1'($urandom), ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial frame receiver feeding the 8-bit parity checker stage. Deserialises a start/data/parity/stop frame from a strobed serial line, computes parity on the fly, and presents the data byte with parity and framing status on a valid/ready output. Sits directly upstream of the parity checker and any byte consumer behind it.

## Interface
- DATA_W, 8, data bits per frame, LSB first; supported range 5..8.
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_stb  input  1  one-cycle strobe; `sd` is sampled only on cycles where it is high.
- sd  input  1  serial data, idle high.
- data_o  output  DATA_W  received data bits.
- par_err_o  output  1  parity mismatch for the presented frame.
- frm_err_o  output  1  stop bit sampled low.
- valid_o  output  1  output holds a frame.
- ready_i  input  1  consumer accepts when `valid_o && ready_i`.
- overrun_o  output  1  sticky; a frame completed while `valid_o` was high and unaccepted.
- ovr_clr  input  1  synchronous clear of `overrun_o`.

## Operation
- FSM states and transitions, evaluated only on `bit_stb` cycles:
  - IDLE -> DATA when `sd`=0 (start bit).
  - DATA: shift `sd` into the shift register at bit index `cnt`. `cnt` runs 0..DATA_W-1. Go to PAR after index DATA_W-1.
  - PAR: sample the parity bit, then go to STOP.
  - STOP: sample the stop bit, then go to IDLE.
- Running parity `p` is cleared on the start bit and XORed with every data bit and with the parity bit.
- Even parity (default): `par_err` = `p`. That is, the total count of ones across the data and parity bits must be even.
- Frame completion on the STOP sample:
  - If `valid_o`=0, or `valid_o && ready_i` in the same cycle: load `data_o`, `par_err_o`, and `frm_err_o` (= !sd), and set `valid_o`.
  - Otherwise: the frame is dropped, `overrun_o` is set, and the output keeps the old frame.
- Frame with a framing error: still delivered, with `frm_err_o`=1. FSM returns to IDLE. If `sd` is still low on the next strobe, that is taken as a new start bit.
- `valid_o` clears on the cycle after `valid_o && ready_i`, unless a new frame loads in that same cycle.
- `overrun_o`:
  - `ovr_clr` has priority over a new overrun in the same cycle.
  - Clearing does not affect a frame in flight.

## Timing
- Reset values: FSM=IDLE, cnt=0, p=0, `data_o`=0, `par_err_o`=0, `frm_err_o`=0, `valid_o`=0, `overrun_o`=0.
- Reset mid-frame aborts the frame. No partial output is produced.
- Latency: `valid_o` rises on the clock edge that samples the stop bit. It is visible one cycle after that strobe cycle.
- `data_o` and the error flags are stable while `valid_o`=1 and not accepted.
- `bit_stb` may be high on consecutive cycles (minimum frame = DATA_W+3 cycles) or sparse. No timeout exists; the FSM waits indefinitely between strobes.
- Output is fully registered. No combinational path from `ready_i` to any output.

## Configuration
- Macro `PARITY_FRAME_RX_ODD_PARITY_EN`.
  - Defined: odd parity; `par_err` = !p.
  - Undefined: even parity as above.
- No other behaviour changes.

## Structure
- Shared package `parity_pkg`:
  - FSM state enum `rx_state_t` (IDLE, DATA, PAR, STOP).
  - Constant `PARITY_DATA_W_MAX` = 8.
- One natural sub-module, `parity_out_reg`. It is the output holding register with the valid/ready and overrun logic, reusable by other byte producers. The FSM and shifter stay in the top.

## Test plan
- Even parity, byte 0x0F, parity bit 0, stop 1, one strobe per cycle -> `data_o`=0x0F, `par_err_o`=0, `frm_err_o`=0, `valid_o` one cycle after the stop strobe.
- Byte 0xA5 with parity bit 1 (even mode) -> `par_err_o`=1, `data_o`=0xA5. Rebuilt with the ODD macro -> `par_err_o`=0.
- Byte 0x3C with stop bit 0 -> `frm_err_o`=1. Then an immediate frame 0x01 -> received correctly once the first frame is accepted.
- `ready_i` held low across two frames 0x11 then 0x22 -> `data_o` stays 0x11, `overrun_o`=1. After accept and `ovr_clr`, both read 0.
- Sparse strobes (every 7 cycles) plus `rst_n` asserted after the 4th data bit -> all outputs at reset values. The next full frame 0x80 is received cleanly.
- Accept and stop sample in the same cycle (0x55 waiting, 0xAA completing, `ready_i`=1) -> `data_o`=0xAA, `valid_o` stays 1, no overrun.
